// File: rtl/cpu_debug_monitor.sv
// Board-side debug/status controller for the CPU top: run/step enable, view register, 7-seg scan.
// Define CPU_DEBUG_MONITOR_STATS_EN to build the execution statistics counters (views 4-7).
module cpu_debug_monitor #(
    parameter int DmAddrBit = 10,
    parameter int RunDiv    = 50000000,
    parameter int ScanDiv   = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 step,
    input  logic [2:0]           view,
    input  logic [9:0]           sel,
    input  logic                 stat_clr,
    input  logic                 halt,
    input  logic                 is_jump,
    input  logic                 is_branch,
    input  logic                 branched,
    input  logic [31:0]          pc_dbg,
    input  logic [31:0]          regfile_data_dbg,
    input  logic [31:0]          datamem_data_dbg,
    input  logic [31:0]          display,
    output logic                 cpu_en,
    output logic [4:0]           regfile_req_dbg,
    output logic [DmAddrBit-1:0] datamem_addr_dbg,
    output logic [31:0]          view_data,
    output logic [7:0]           seg,
    output logic [7:0]           an
);
    localparam int RunW  = (RunDiv  > 1) ? $clog2(RunDiv)  : 1;
    localparam int ScanW = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;
    localparam logic [RunW-1:0]  RunLast  = RunW'(RunDiv - 1);
    localparam logic [ScanW-1:0] ScanLast = ScanW'(ScanDiv - 1);

    logic [RunW-1:0]  runCnt_q, runCnt_d;
    logic             stepSync_q, stepPrev_q;
    logic             cpuEn_q, cpuEn_d;
    logic [31:0]      viewData_q, viewData_d;
    logic [ScanW-1:0] scanCnt_q, scanCnt_d;
    logic [2:0]       digit_q, digit_d;
    logic [7:0]       an_q, an_d, seg_q, seg_d;
    logic             runWrap, stepEdge, scanWrap;
    logic [3:0]       nibble;

    function automatic logic [7:0] hexSeg(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    assign regfile_req_dbg  = sel[4:0];
    assign datamem_addr_dbg = DmAddrBit'(sel);

    assign runWrap  = (runCnt_q == RunLast);
    assign stepEdge = stepSync_q & ~stepPrev_q;
    assign scanWrap = (scanCnt_q == ScanLast);

    // The !cpuEn_q term keeps every enable a single-cycle pulse, even with RunDiv=1.
    always_comb begin
        runCnt_d = runCnt_q + 1'b1;
        if (!run || runWrap) begin
            runCnt_d = '0;
        end
        cpuEn_d = ~cpuEn_q & ~halt & (run ? runWrap : stepEdge);
    end

`ifdef CPU_DEBUG_MONITOR_STATS_EN
    logic [31:0] cycleCnt_q, jumpCnt_q, branchCnt_q, takenCnt_q;
    logic [31:0] cycleCnt_d, jumpCnt_d, branchCnt_d, takenCnt_d;

    function automatic logic [31:0] satInc(input logic [31:0] v, input logic inc);
        return (inc && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    always_comb begin
        cycleCnt_d  = satInc(cycleCnt_q, cpuEn_q);
        jumpCnt_d   = satInc(jumpCnt_q, cpuEn_q & is_jump);
        branchCnt_d = satInc(branchCnt_q, cpuEn_q & is_branch);
        takenCnt_d  = satInc(takenCnt_q, cpuEn_q & is_branch & branched);
        if (stat_clr) begin
            cycleCnt_d  = '0;
            jumpCnt_d   = '0;
            branchCnt_d = '0;
            takenCnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycleCnt_q  <= '0;
            jumpCnt_q   <= '0;
            branchCnt_q <= '0;
            takenCnt_q  <= '0;
        end else begin
            cycleCnt_q  <= cycleCnt_d;
            jumpCnt_q   <= jumpCnt_d;
            branchCnt_q <= branchCnt_d;
            takenCnt_q  <= takenCnt_d;
        end
    end
`else
    logic unusedStatInputs;
    assign unusedStatInputs = ^{stat_clr, is_jump, is_branch, branched};
`endif

    always_comb begin
        viewData_d = '0;
        case (view)
            3'd0: viewData_d = display;
            3'd1: viewData_d = pc_dbg;
            3'd2: viewData_d = regfile_data_dbg;
            3'd3: viewData_d = datamem_data_dbg;
`ifdef CPU_DEBUG_MONITOR_STATS_EN
            3'd4: viewData_d = cycleCnt_q;
            3'd5: viewData_d = jumpCnt_q;
            3'd6: viewData_d = branchCnt_q;
            3'd7: viewData_d = takenCnt_q;
`endif
            default: viewData_d = '0;
        endcase
    end

    // an and seg are both derived from digit_q so they always change together.
    always_comb begin
        scanCnt_d = scanWrap ? '0 : scanCnt_q + 1'b1;
        digit_d   = scanWrap ? digit_q + 3'd1 : digit_q;
        nibble    = 4'(viewData_q >> {digit_q, 2'b00});
        an_d      = ~(8'd1 << digit_q);
        seg_d     = hexSeg(nibble);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            runCnt_q   <= '0;
            stepSync_q <= 1'b0;
            stepPrev_q <= 1'b0;
            cpuEn_q    <= 1'b0;
            viewData_q <= '0;
            scanCnt_q  <= '0;
            digit_q    <= '0;
            an_q       <= 8'hFE;
            seg_q      <= 8'hC0;
        end else begin
            runCnt_q   <= runCnt_d;
            stepSync_q <= step;
            stepPrev_q <= stepSync_q;
            cpuEn_q    <= cpuEn_d;
            viewData_q <= viewData_d;
            scanCnt_q  <= scanCnt_d;
            digit_q    <= digit_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign cpu_en    = cpuEn_q;
    assign view_data = viewData_q;
    assign an        = an_q;
    assign seg       = seg_q;
endmodule

// File: tb/tb_cpu_debug_monitor.sv
// Randomized scoreboard bench for cpu_debug_monitor (RunDiv=4, ScanDiv=2).
// Expectations come from a cycle-indexed behavioural model; a negedge monitor compares.
module tb_cpu_debug_monitor;
    localparam int RunDiv    = 4;
    localparam int ScanDiv   = 2;
    localparam int DmAddrBit = 10;
    localparam int MaxCyc    = 4096;
    localparam int KView = 0, KAn = 1, KSeg = 2, KReq = 3, KAddr = 4, KEn = 5;

    typedef struct packed {
        int          cyc;
        int          kind;
        logic [31:0] exp;
    } expect_t;

    logic                 clk = 1'b0;
    logic                 rst_n, run, step, stat_clr, halt, is_jump, is_branch, branched;
    logic [2:0]           view;
    logic [9:0]           sel;
    logic [31:0]          pc_dbg, regfile_data_dbg, datamem_data_dbg, display;
    logic                 cpu_en;
    logic [4:0]           regfile_req_dbg;
    logic [DmAddrBit-1:0] datamem_addr_dbg;
    logic [31:0]          view_data;
    logic [7:0]           seg, an;

    logic [31:0] regs [32];
    logic [31:0] mem  [1024];
    logic [7:0]  hexTab [16];

    bit          runAt [MaxCyc];
    bit          stepAt [MaxCyc];
    bit          pulseAt [MaxCyc];
    logic [31:0] viewAt [MaxCyc];
    int          base, runStart;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    expect_t     expQ [$];
    int          pulseQ [$];
`ifdef CPU_DEBUG_MONITOR_STATS_EN
    logic [31:0] nCycles = 0, nJumps = 0, nBranches = 0, nTaken = 0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behaves like the CPU: debug reads answer combinationally from the requested index.
    assign regfile_data_dbg = regs[regfile_req_dbg];
    assign datamem_data_dbg = mem[datamem_addr_dbg];

    cpu_debug_monitor #(
        .DmAddrBit(DmAddrBit),
        .RunDiv   (RunDiv),
        .ScanDiv  (ScanDiv)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .run             (run),
        .step            (step),
        .view            (view),
        .sel             (sel),
        .stat_clr        (stat_clr),
        .halt            (halt),
        .is_jump         (is_jump),
        .is_branch       (is_branch),
        .branched        (branched),
        .pc_dbg          (pc_dbg),
        .regfile_data_dbg(regfile_data_dbg),
        .datamem_data_dbg(datamem_data_dbg),
        .display         (display),
        .cpu_en          (cpu_en),
        .regfile_req_dbg (regfile_req_dbg),
        .datamem_addr_dbg(datamem_addr_dbg),
        .view_data       (view_data),
        .seg             (seg),
        .an              (an)
    );

    function automatic string kindName(input int k);
        case (k)
            KView:   return "view_data";
            KAn:     return "an";
            KSeg:    return "seg";
            KReq:    return "regfile_req_dbg";
            KAddr:   return "datamem_addr_dbg";
            default: return "cpu_en";
        endcase
    endfunction

    function automatic logic [31:0] actualOf(input int k);
        case (k)
            KView:   return view_data;
            KAn:     return {24'd0, an};
            KSeg:    return {24'd0, seg};
            KReq:    return {27'd0, regfile_req_dbg};
            KAddr:   return {22'd0, datamem_addr_dbg};
            default: return {31'd0, cpu_en};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        int i;
        i = 0;
        while (i < expQ.size()) begin
            if (expQ[i].cyc == cyc) begin
                checkOutput(kindName(expQ[i].kind), actualOf(expQ[i].kind), expQ[i].exp);
                expQ.delete(i);
            end else if (expQ[i].cyc < cyc) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL stale %s check for cycle %0d, expected %h", kindName(expQ[i].kind), expQ[i].cyc, expQ[i].exp);
                expQ.delete(i);
            end else begin
                i++;
            end
        end
        while (pulseQ.size() > 0 && pulseQ[0] < cyc) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL cpu_en pulse missing: got 0 at cycle %0d, expected 1", pulseQ[0]);
            void'(pulseQ.pop_front());
        end
        if (cpu_en === 1'b1) begin
            vectors++;
            if (pulseQ.size() > 0 && pulseQ[0] == cyc) begin
                void'(pulseQ.pop_front());
            end else begin
                miscompares++;
                $display("[TB] FAIL cpu_en unexpected pulse: got 1 at cycle %0d, expected 0", cyc);
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic randomData();
        display = $urandom;
        pc_dbg  = $urandom;
        sel     = 10'($urandom_range(0, 1023));
        view    = 3'($urandom_range(0, 7));
    endtask

    // Called once per cycle after the inputs for that cycle are driven; pushes what the
    // outputs must show and updates the statistics model.
    task automatic applyStimulus();
        int          now;
        int          d;
        logic [31:0] v;
        bit          pe;
        if (run) step = 1'b0;
        now         = cyc;
        runAt[now]  = run;
        stepAt[now] = step;
        if (run && !runAt[now-1]) runStart = now;

        case (view)
            3'd0: v = display;
            3'd1: v = pc_dbg;
            3'd2: v = regs[sel[4:0]];
            3'd3: v = mem[sel];
`ifdef CPU_DEBUG_MONITOR_STATS_EN
            3'd4: v = nCycles;
            3'd5: v = nJumps;
            3'd6: v = nBranches;
            3'd7: v = nTaken;
`endif
            default: v = 32'd0;
        endcase
        viewAt[now+1] = v;
        expQ.push_back('{now + 1, KView, v});
        expQ.push_back('{now, KReq, {27'd0, sel[4:0]}});
        expQ.push_back('{now, KAddr, {22'd0, sel}});

        d = ((now - base) / ScanDiv) % 8;
        expQ.push_back('{now + 1, KAn, {24'd0, 8'(~(8'd1 << d))}});
        expQ.push_back('{now + 1, KSeg, {24'd0, hexTab[4'(viewAt[now] >> (4 * d))]}});

        pe = !halt && !pulseAt[now] &&
             (run ? (((now + 1 - runStart) % RunDiv) == 0) : (stepAt[now-1] && !stepAt[now-2]));
        pulseAt[now+1] = pe;
        if (pe) pulseQ.push_back(now + 1);

`ifdef CPU_DEBUG_MONITOR_STATS_EN
        if (stat_clr) begin
            nCycles = 0; nJumps = 0; nBranches = 0; nTaken = 0;
        end else if (pulseAt[now]) begin
            nCycles++;
            if (is_jump) nJumps++;
            if (is_branch) nBranches++;
            if (is_branch && branched) nTaken++;
        end
`endif
    endtask

    initial begin
        logic [9:0] jmpPat, brPat, tkPat;
        hexTab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        regs[5] = 32'hDEADBEEF;
        for (int i = 0; i < MaxCyc; i++) viewAt[i] = 32'd0;

        rst_n = 1'b0; run = 1'b1; step = 1'b0; halt = 1'b0; stat_clr = 1'b0;
        is_jump = 1'b0; is_branch = 1'b0; branched = 1'b0;
        view = 3'd0; sel = 10'd0; display = 32'd0; pc_dbg = 32'd0;

        for (int i = 0; i < 3; i++) begin
            nextCycle();
            expQ.push_back('{cyc, KEn, 32'd0});
            expQ.push_back('{cyc, KAn, 32'h0000_00FE});
            expQ.push_back('{cyc, KSeg, 32'h0000_00C0});
            expQ.push_back('{cyc, KView, 32'd0});
            runAt[cyc] = 1'b1;
        end
        rst_n = 1'b1;
        base = cyc;
        runStart = cyc;
        randomData();
        applyStimulus();

        // Free run: clean pulses first, then halt drops some of them.
        for (int i = 0; i < 32; i++) begin
            nextCycle();
            randomData();
            halt = (i >= 20) ? 1'($urandom_range(0, 1)) : 1'b0;
            applyStimulus();
        end

        // Single step, then the same step while halted.
        for (int h = 0; h < 2; h++) begin
            for (int i = 0; i < 17; i++) begin
                nextCycle();
                randomData();
                run  = 1'b0;
                halt = 1'(h);
                step = (i >= 4 && i < 14);
                applyStimulus();
            end
        end
        halt = 1'b0;

        nextCycle(); randomData(); view = 3'd2; sel = 10'd5; applyStimulus();
        nextCycle(); randomData(); view = 3'd1; pc_dbg = 32'h0000_0C04; applyStimulus();

        // Ten steps with 3 jumps, 4 branches, 2 taken, bracketed by stat_clr.
        nextCycle(); randomData(); stat_clr = 1'b1; applyStimulus();
        stat_clr = 1'b0;
        jmpPat = 10'b0010010010;
        brPat  = 10'b0101010100;
        tkPat  = 10'b0100010000;
        for (int s = 0; s < 10; s++) begin
            for (int i = 0; i < 6; i++) begin
                nextCycle();
                randomData();
                step      = (i < 3);
                is_jump   = jmpPat[s];
                is_branch = brPat[s];
                branched  = tkPat[s];
                applyStimulus();
            end
        end
        is_jump = 1'b0; is_branch = 1'b0; branched = 1'b0;
        for (int k = 0; k < 10; k++) begin
            nextCycle();
            randomData();
            view = 3'(4 + (k % 4));
            stat_clr = (k == 4);
            applyStimulus();
        end
        stat_clr = 1'b0;

        // Scan a fixed pattern across two full digit rotations.
        for (int i = 0; i < 36; i++) begin
            nextCycle();
            randomData();
            view = 3'd1;
            pc_dbg = 32'h0123_ABCD;
            applyStimulus();
        end

        for (int i = 0; i < 400; i++) begin
            nextCycle();
            randomData();
            if ($urandom_range(0, 39) == 0) run = ~run;
            if (!run && $urandom_range(0, 2) == 0) step = ~step;
            halt      = ($urandom_range(0, 5) == 0);
            is_jump   = 1'($urandom);
            is_branch = 1'($urandom);
            branched  = 1'($urandom);
            stat_clr  = ($urandom_range(0, 29) == 0);
            applyStimulus();
        end

        // Five clean run pulses to finish.
        for (int i = 0; i < 22; i++) begin
            nextCycle();
            randomData();
            run = 1'b1; halt = 1'b0; stat_clr = 1'b0;
            applyStimulus();
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        while (pulseQ.size() > 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL cpu_en pulse never seen: got none, expected one at cycle %0d", pulseQ.pop_front());
        end
        while (expQ.size() > 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unchecked %s: got none, expected %h at cycle %0d", kindName(expQ[0].kind), expQ[0].exp, expQ[0].cyc);
            void'(expQ.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
